// File: rtl/queue.sv
// queue: single-clock circular-buffer FIFO with a registered head output.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  storage entries (power of two, >= 2)
//
// Ports (in positional order)
//   in     data word to enqueue
//   ck     clock, all state updates on the rising edge
//   ld     push request
//   pp     pop request
//   rst_n  synchronous reset, active HIGH (name kept for port compatibility)
//   em     registered empty flag
//   out    registered data output, holds the last popped word
//
// Optional feature
//   QUEUE_OVERWRITE_EN  when defined, a push alone into a full queue replaces the
//                       oldest entry instead of being dropped.
module queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic [WIDTH-1:0] in,
    input  logic             ck,
    input  logic             ld,
    input  logic             pp,
    input  logic             rst_n,
    output logic             em,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             overwrite;
    logic             wr_en;
    logic             rd_adv;

    always_comb begin
        full    = (count == FULL_COUNT);
        do_pop  = pp && (count != '0);
        // A pop in the same edge frees the slot, so a full queue still accepts the push.
        do_push = ld && (!full || do_pop);
`ifdef QUEUE_OVERWRITE_EN
        overwrite = ld && !pp && full;
`else
        overwrite = 1'b0;
`endif
        // Overwrite writes into the oldest slot (wr_ptr == rd_ptr when full) and
        // moves both pointers, leaving occupancy at DEPTH.
        wr_en  = do_push || overwrite;
        rd_adv = do_pop || overwrite;

        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            em     <= 1'b1;
            out    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_pop) begin
                out <= mem[rd_ptr];
            end
            count <= count_next;
            em    <= (count_next == '0);
        end
    end

    // Storage is not reset; pointers and count guarantee stale words are never read.
    always_ff @(posedge ck) begin
        if (!rst_n && wr_en) begin
            mem[wr_ptr] <= in;
        end
    end

endmodule

// File: tb/tb_queue.sv
// tb_queue: self-checking bench for queue. Directed scenarios compare against
// fixed expected values; the random scenario compares every cycle against a
// behavioural FIFO model built on a SystemVerilog queue.
module tb_queue;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;

    logic [WIDTH-1:0] in;
    logic             ck;
    logic             ld;
    logic             pp;
    logic             rst_n;
    logic             em;
    logic [WIDTH-1:0] out;

    int n_checks;
    int n_fail;

    // Behavioural model state
    logic [WIDTH-1:0] mdl_q[$];
    logic [WIDTH-1:0] mdl_out;

    queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .in   (in),
        .ck   (ck),
        .ld   (ld),
        .pp   (pp),
        .rst_n(rst_n),
        .em   (em),
        .out  (out)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic model_update(input logic r, input logic l, input logic p,
                                input logic [WIDTH-1:0] d);
        bit can_pop;
        bit room;
        if (r) begin
            mdl_q.delete();
            mdl_out = '0;
        end else begin
            can_pop = p && (mdl_q.size() > 0);
            room    = (mdl_q.size() < DEPTH);
            if (can_pop) mdl_out = mdl_q.pop_front();
            if (l) begin
                if (room || can_pop) begin
                    mdl_q.push_back(d);
                end else begin
`ifdef QUEUE_OVERWRITE_EN
                    void'(mdl_q.pop_front());
                    mdl_q.push_back(d);
`endif
                end
            end
        end
    endtask

    // Apply one clock edge worth of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic l, input logic p,
                        input logic [WIDTH-1:0] d);
        rst_n = r;
        ld    = l;
        pp    = p;
        in    = d;
        @(posedge ck);
        model_update(r, l, p, d);
        #1;
        rst_n = 1'b0;
        ld    = 1'b0;
        pp    = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 8'hAA);
        n_checks++;
        if (em !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_em: got %b expected 1", em);
        end
        n_checks++;
        if (out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out: got %0h expected 00", out);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (em !== 1'b1 || out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pop_ignored: got em=%b out=%0h expected em=1 out=00", em, out);
        end
    endtask

    task automatic test_order();
        logic [WIDTH-1:0] exp_out[4];
        exp_out = '{8'h10, 8'h09, 8'h0A, 8'h0A};
        step(1'b0, 1'b1, 1'b0, 8'h10);
        n_checks++;
        if (em !== 1'b0) begin
            n_fail++;
            $display("FAIL order_em_after_push: got %b expected 0", em);
        end
        step(1'b0, 1'b1, 1'b0, 8'h09);
        step(1'b0, 1'b1, 1'b0, 8'h0A);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (out !== exp_out[i]) begin
                n_fail++;
                $display("FAIL order_pop%0d: got %0h expected %0h", i, out, exp_out[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (em !== 1'b1) begin
                    n_fail++;
                    $display("FAIL order_em_after_third_pop: got %b expected 1", em);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        // Empty queue: push+pop performs only the push, out holds 0x0A.
        step(1'b0, 1'b1, 1'b1, 8'h01);
        n_checks++;
        if (out !== 8'h0A || em !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_empty_no_bypass: got out=%0h em=%b expected out=0a em=0", out, em);
        end
        step(1'b0, 1'b1, 1'b1, 8'h02);
        n_checks++;
        if (out !== 8'h01 || em !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_push_pop: got out=%0h em=%b expected out=01 em=0", out, em);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (out !== 8'h02 || em !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_next_pop: got out=%0h em=%b expected out=02 em=1", out, em);
        end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] first;
`ifdef QUEUE_OVERWRITE_EN
        first = 8'h01;
`else
        first = 8'h00;
`endif
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'h08);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (out !== first + 8'(i)) begin
                n_fail++;
                $display("FAIL full_pop%0d: got %0h expected %0h", i, out, first + 8'(i));
            end
        end
        n_checks++;
        if (em !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drained_em: got %b expected 1", em);
        end
        // Simultaneous push/pop at full keeps occupancy at DEPTH.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b0, 1'b1, 1'b1, 8'h28);
        n_checks++;
        if (out !== 8'h20) begin
            n_fail++;
            $display("FAIL full_push_pop: got %0h expected 20", out);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            n_checks++;
            if (out !== 8'(8'h21 + i)) begin
                n_fail++;
                $display("FAIL full_pp_pop%0d: got %0h expected %0h", i, out, 8'(8'h21 + i));
            end
        end
        n_checks++;
        if (em !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pp_drained_em: got %b expected 1", em);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(i));
            n_checks++;
            if (out !== 8'(i - 1)) begin
                n_fail++;
                $display("FAIL wrap_%0d: got %0h expected %0h", i, out, 8'(i - 1));
            end
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (out !== 8'd19 || em !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_last: got out=%0h em=%b expected out=13 em=1", out, em);
        end
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, 1'b0, 8'h31);
        step(1'b0, 1'b1, 1'b0, 8'h32);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        n_checks++;
        if (em !== 1'b1 || out !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got em=%b out=%0h expected em=1 out=00", em, out);
        end
    endtask

    task automatic test_random();
        logic r;
        logic l;
        logic p;
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 49) == 0);
            l = ($urandom_range(0, 99) < 55);
            p = ($urandom_range(0, 99) < 45);
            d = WIDTH'($urandom);
            step(r, l, p, d);
            n_checks++;
            if (out !== mdl_out || em !== (mdl_q.size() == 0)) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got out=%0h em=%b expected out=%0h em=%b",
                         i, out, em, mdl_out, (mdl_q.size() == 0));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mdl_out  = '0;
        rst_n    = 1'b1;
        ld       = 1'b0;
        pp       = 1'b0;
        in       = '0;
        test_reset();
        test_order();
        test_simultaneous();
        test_full();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/queue.md
QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter: WIDTH, default 8, data word width in bits.
REQ-002 Parameter: DEPTH, default 8, storage entries; power of two, >= 2.
REQ-003 Port: ck  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous and active-high (1 = reset), name kept for port compatibility.
REQ-005 Port: in  input  WIDTH  data word to enqueue.
REQ-006 Port: ld  input  1  push request; enqueue `in` at the rising edge.
REQ-007 Port: pp  input  1  pop request; dequeue the head word at the rising edge.
REQ-008 Port: em  output  1  empty flag; 1 when occupancy is 0.
REQ-009 Port: out  output  WIDTH  registered data output; holds the last popped word.
REQ-010 Port order SHALL be in, ck, ld, pp, rst_n, em, out, to support positional instantiation.

Function
REQ-011 Storage SHALL be a circular buffer of DEPTH words with write pointer, read pointer and occupancy counter of clog2(DEPTH+1) bits.
REQ-012 Push with count < DEPTH SHALL write `in` at the write pointer, advance the pointer modulo DEPTH and increment count.
REQ-013 Pop with count > 0 SHALL load `out` with the word at the read pointer in the same edge, advance the read pointer modulo DEPTH and decrement count; 1-cycle latency from the pp edge to `out`.
REQ-014 Pop with count == 0 SHALL be ignored; `out` holds its value; no pointer change.
REQ-015 No bypass: a push and pop on an empty queue SHALL perform only the push; `out` unchanged.
REQ-016 A push and pop with 0 < count SHALL perform both; count unchanged; `out` gets the old head.
REQ-017 At count == DEPTH, a simultaneous push and pop SHALL perform both, with count remaining DEPTH.
REQ-018 em SHALL be a registered flag equal to (count == 0) after every edge, with no combinational path from inputs.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 without loss of order; output order is strict FIFO.
REQ-020 When ld or pp is X/unused, the design requirement is defined only for 0/1 inputs.

Reset
REQ-021 While rst_n == 1 at a rising edge, the pointers and count SHALL clear to 0, em to 1 and out to 0; ld/pp SHALL be ignored in that cycle.
REQ-022 Storage contents SHALL not require reset; stale entries SHALL never be visible after reset.
REQ-023 Reset asserted mid-operation SHALL discard all queued words.

Configuration
REQ-024 Macro QUEUE_OVERWRITE_EN: when defined, a push alone at count == DEPTH SHALL overwrite the oldest entry and advance both pointers, with count remaining DEPTH.
REQ-025 Without QUEUE_OVERWRITE_EN, a push alone at count == DEPTH SHALL be dropped; the queue contents and pointers SHALL remain unchanged.

Verification
REQ-026 Reset test: hold rst_n=1 for 1 edge with ld=1 and pp=1 -> em=1, out=0x00, and the following pop is ignored.
REQ-027 Order test: push 0x10, 0x09, 0x0A on three edges, then pp=1 for 4 edges -> out=0x10, then 0x09, then 0x0A, then holds 0x0A; em=0 after the first push; em=1 after the third pop edge.
REQ-028 Simultaneous test: with queue holding {0x01}, ld=1 (in=0x02) and pp=1 on one edge -> out=0x01, em=0; the next pop gives out=0x02.
REQ-029 Full/wrap test (DEPTH=8): push 0x00..0x07, then push 0x08 -> without the macro the queue pops 0x00..0x07; with QUEUE_OVERWRITE_EN it pops 0x01..0x08.
REQ-030 Wrap test: run 20 interleaved push/pop pairs with values 0..19 -> out is the strictly ascending sequence with no loss.
REQ-031 Mid-reset test: push 3 words, assert rst_n for 1 edge, then pop -> em=1, out=0x00, and the pop is ignored.
